mux_nx1_stream: RTL
===================

# mux_nx1_stream

Parametrised, registered N:1 stream multiplexer; the next generation of the team's 16x1 4-bit mux. It selects one of `N_CH` valid/ready input channels, either a software-loaded fixed channel or round-robin over all requesting channels. The selected beat goes through a single output register with valid/ready back-pressure. It sits between per-channel producers and a single shared consumer.

## Interface
- `N_CH`, default 16: number of input channels, at least 2.
- `W`, default 4: data width per channel.
- `SEL_W`, default `$clog2(N_CH)`: select/pointer width. It is derived and must not be overridden.
- `clk`, input, 1 bit: the single clock. All logic is on its rising edge.
- `rst`, input, 1 bit: **synchronous, active-low reset**, sampled on the `clk` rising edge.
- `in_data`, input, `[N_CH][W]`: per-channel data.
- `in_valid`, input, `[N_CH]`: per-channel valid.
- `in_ready`, output, `[N_CH]`: per-channel ready. It is combinational and one-hot or zero.
- `mode`, input, 1 bit: `MODE_FIXED` (0) or `MODE_RR` (1).
- `sel`, input, `SEL_W` bits: fixed-channel select value.
- `sel_load`, input, 1 bit: loads `sel` into `sel_q`.
- `sel_err`, output, 1 bit: 1-cycle pulse when a `sel_load` is rejected.
- `out_data`, output, `W` bits: registered output data.
- `out_valid`, output, 1 bit: registered output valid.
- `out_ready`, input, 1 bit: consumer ready.

## Operation
- `accept = !out_valid || out_ready`. This is the output register's capacity this cycle.
- A transfer on channel k occurs when `in_valid[k] && in_ready[k]`. It loads `out_data <= in_data[k]` and sets `out_valid <= 1`.
- When `out_valid && out_ready` and no new transfer occurs, `out_valid <= 0`. `out_data` holds its value.
- **Select register:**
  - `sel_load` with `sel < N_CH` gives `sel_q <= sel`.
  - `sel_load` with `sel >= N_CH` leaves `sel_q` unchanged and gives `sel_err <= 1` for one cycle.
- **`MODE_FIXED`:**
  - `in_ready[sel_q] = accept`. All other `in_ready` bits are 0.
  - Other channels' `in_valid` is ignored.
- **`MODE_RR`:**
  - Grant g is the first k with `in_valid[k]`, searching `ptr, ptr+1, …, N_CH-1, 0, …, ptr-1`.
  - `in_ready[g] = accept`. When no channel is valid, all `in_ready` bits are 0.
  - On each transfer, `ptr <= (g == N_CH-1) ? 0 : g+1`.
  - `ptr` is unchanged when no transfer occurs, including while stalled by `accept = 0`.
- **Mode tracking:**
  - `mode_q` registers `mode`.
  - On the cycle `mode` = RR while `mode_q` = FIXED, `ptr <= sel_q` and that cycle still arbitrates from the old `ptr`.
  - The mode used for selection is the live `mode` input.
- **Simultaneous events:**
  - `sel_load` in the same cycle as a fixed-mode transfer: the transfer uses the old `sel_q`, and the new value applies from the next cycle.
  - `sel_load` while `mode_q` = FIXED and `mode` = RR: `ptr` takes the old `sel_q`.
- **Reset (rst = 0 on an edge), including mid-stream:**
  - `out_valid = 0`, `out_data = 0`, `sel_q = 0`, `ptr = 0`, `mode_q = 0`, `sel_err = 0`.
  - While `rst = 0`, `in_ready` is all 0.
  - Any beat held in the output register is dropped.

## Timing
- Latency is 1 cycle: a beat accepted at edge t appears with `out_valid = 1` after edge t.
- Throughput is 1 beat/cycle when `out_ready` is held at 1.
- Back-pressure:
  - `out_valid && !out_ready` gives `accept = 0`, so all `in_ready` are 0.
  - `out_data` and `out_valid` stay stable until taken.
- `in_ready` depends combinationally on `out_valid`, `out_ready`, `in_valid`, `mode`, `sel_q` and `ptr`. There is no combinational path from `in_data`.
- `sel_load` takes effect for the transfer on the following cycle.
- `sel_err` is asserted exactly one cycle after the rejected load edge.

## Structure
- **Package `mux_pkg`:**
  - `typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_e`.
  - Default-parameter constants `MUX_N_CH_DEF = 16` and `MUX_W_DEF = 4`.
- **Sub-module `mux_rr_pick`:**
  - Parameterised by `N_CH`.
  - Inputs `req[N_CH]` and `ptr`; outputs `gnt_idx` and `gnt_any`.
  - Combinational rotate-priority search.
- The top level holds `sel_q`, `ptr`, `mode_q`, the output register and `sel_err`.

## Test plan
1. **Fixed mode, no stall.** Reset, then `sel_load` with `sel = 5`; `in_data[5] = 4'hA`, all `in_valid = 1`, `out_ready = 1`. Required: `out_data = A` one cycle later; only `in_ready[5]` ever high.
2. **Round-robin.** `mode = RR`, valid on channels 2, 7 and 15, `out_ready = 1`, starting `ptr = 0`. Required: grant order is 2, 7, 15, 2, …; after the grant to 15, `ptr` wraps to 0.
3. **Back-pressure.** `out_ready = 0` for 3 cycles after a beat is held. Required: `in_ready` all 0, `out_data` stable, `ptr` unchanged. After `out_ready = 1`, the next grant is as expected.
4. **Rejected select.** `N_CH = 12`, `sel_load` with `sel = 13`. Required: `sel_err` pulses 1 cycle, `sel_q` keeps its old value. Then `sel = 11` loads cleanly.
5. **Reset mid-stream.** Assert `rst = 0` while `out_valid = 1` in RR mode with `ptr = 9`. Required: next cycle `out_valid = 0`, `out_data = 0`, `ptr = 0`, `in_ready` all 0 while reset is held.
6. **Mode switch.** With `sel_q = 6`, set `mode` from FIXED to RR with all channels valid. Required: the first RR grant after the switch cycle is channel 6.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and default sizing for the N:1 stream multiplexer.
package mux_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mux_mode_e;

   localparam int MUX_N_CH_DEF = 16;
   localparam int MUX_W_DEF    = 4;

endpackage

// File: rtl/mux_rr_pick.sv
// Rotating-priority picker: first requesting channel at or after ptr, wrapping at N_CH.
module mux_rr_pick
   import mux_pkg::*;
#(
   parameter  int N_CH  = MUX_N_CH_DEF,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);

   localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

   logic [SEL_W:0] idx;

   // ptr is always below N_CH, so one conditional subtract is enough to wrap
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int i = 0; i < N_CH; i++) begin
         idx = {1'b0, ptr} + (SEL_W + 1)'(i);
         if (idx >= N_CH_W) begin
            idx = idx - N_CH_W;
         end
         if (!gnt_any && req[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mux_nx1_stream.sv
// Registered N:1 valid/ready multiplexer with a fixed-channel or round-robin selection mode.
module mux_nx1_stream
   import mux_pkg::*;
#(
   parameter int N_CH  = MUX_N_CH_DEF,
   parameter int W     = MUX_W_DEF,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0][W-1:0]  in_data,
   input  logic [N_CH-1:0]         in_valid,
   output logic [N_CH-1:0]         in_ready,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    sel_load,
   output logic                    sel_err,
   output logic [W-1:0]            out_data,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam logic [SEL_W:0]   N_CH_W = (SEL_W + 1)'(N_CH);
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   mux_mode_e        mode_q, mode_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             sel_err_q, sel_err_d;

   logic             accept;
   logic             xfer;
   logic [SEL_W-1:0] xfer_idx;
   logic [SEL_W-1:0] gnt_idx;
   logic             gnt_any;
   logic             mode_rr;
   logic             rr_entry;

   mux_rr_pick #(.N_CH(N_CH)) u_pick (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign mode_rr  = (mode == MODE_RR);
   assign rr_entry = mode_rr && (mode_q == MODE_FIXED);
   assign accept   = !out_valid_q || out_ready;

   // Ready is held low throughout reset so nothing is consumed from producers
   always_comb begin
      in_ready = '0;
      if (rst) begin
         if (mode_rr) begin
            if (gnt_any) begin
               in_ready[gnt_idx] = accept;
            end
         end else begin
            in_ready[sel_q] = accept;
         end
      end
   end

   assign xfer     = |(in_valid & in_ready);
   assign xfer_idx = mode_rr ? gnt_idx : sel_q;

   // Entering round-robin reseeds ptr from the previously fixed channel
   always_comb begin
      out_valid_d = xfer || (out_valid_q && !out_ready);
      out_data_d  = xfer ? in_data[xfer_idx] : out_data_q;
      sel_d       = sel_q;
      sel_err_d   = 1'b0;
      if (sel_load) begin
         if ({1'b0, sel} < N_CH_W) begin
            sel_d = sel;
         end else begin
            sel_err_d = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (rr_entry) begin
         ptr_d = sel_q;
      end else if (xfer && mode_rr) begin
         ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + SEL_W'(1);
      end
      mode_d = mux_mode_e'(mode);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sel_q       <= '0;
         ptr_q       <= '0;
         mode_q      <= MODE_FIXED;
         sel_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         mode_q      <= mode_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sel_err   = sel_err_q;

endmodule
